// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data port. Accepts one load/store at a
// time, holds it for WAIT_CYCLES extra cycles, then pulses ack with read data
// and an error flag. Stores commit on the clock edge that ends the ack cycle.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        byte_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic        we;
    logic        byte_en;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  mreq_t                 lreq, cur;
  logic                  accept, enter_resp, cur_err, wr_en;
  logic [29:0]           cur_widx;
  logic [ADDR_WIDTH-1:0] cur_idx, lreq_idx;
  logic [1:0]            cur_lane, lreq_lane;
  logic [3:0][7:0]       rd_word;
  logic [31:0]           rd_val;

  // Storage is deliberately left unreset: it models a RAM.
  logic [3:0][7:0]       mem [DEPTH];

  // State and wait counter; async reset drops any request in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic plus the handshake outputs decoded from state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    ack       = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready = reset;
        if (req && reset) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_RESP;
        else           cnt_nxt   = cnt - CW'(1);
      end
      S_RESP: begin
        ack       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept = ready && req;

  // With zero wait states RESP is entered on the accept edge itself, before
  // the request is latched, so the response is built from the live inputs
  // while idle and from the latched copy otherwise.
  always_comb begin
    if (state == S_IDLE) begin
      cur.we      = we;
      cur.byte_en = byte_en;
      cur.addr    = addr;
      cur.wdata   = wdata;
    end else begin
      cur = lreq;
    end
  end

  assign cur_widx  = cur.addr[31:2];
  assign cur_idx   = cur.addr[ADDR_WIDTH+1:2];
  assign cur_lane  = cur.addr[1:0];
  assign lreq_idx  = lreq.addr[ADDR_WIDTH+1:2];
  assign lreq_lane = lreq.addr[1:0];

  // Out of range: any word-index bit above the array size is set.
  assign cur_err = ((cur_widx >> ADDR_WIDTH) != '0) ||
                   (!cur.byte_en && (cur_lane != 2'b00));

  assign rd_word    = mem[cur_idx];
  assign rd_val     = cur.byte_en ? {24'b0, rd_word[cur_lane]} : rd_word;
  assign enter_resp = (state != S_RESP) && (state_nxt == S_RESP);

  // Request capture on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      lreq <= '0;
    else if (accept) lreq <= cur;
  end

  // Response registers: loaded on entry to RESP, cleared when leaving it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
      err   <= 1'b0;
    end else if (enter_resp) begin
      err   <= cur_err;
      rdata <= (cur.we || cur_err) ? 32'b0 : rd_val;
    end else if (state == S_RESP) begin
      rdata <= '0;
      err   <= 1'b0;
    end
  end

  // err still holds this request's flag during RESP, so it gates the write.
  assign wr_en = (state == S_RESP) && lreq.we && !err;

  // Store commit: whole word, or the single little-endian lane for bytes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (!lreq.byte_en || (lreq_lane == 2'(l)))
          mem[lreq_idx][l] <= lreq.byte_en ? lreq.wdata[7:0] : lreq.wdata[8*l +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 and 0 wait states) driven by
// directed scenarios and random traffic, checked every cycle against a
// transaction-level model (one pending request, due cycle, word-array memory).
module tb_data_mem_responder;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;
  localparam int WC0   = 2;
  localparam int WC1   = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req   [2];
  logic        we    [2];
  logic        be    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic        ack   [2];
  logic        err   [2];
  logic [31:0] rdata [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC0)) u_dut_w2 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .byte_en(be[0]),
    .addr(addr[0]), .wdata(wdata[0]), .ready(ready[0]), .ack(ack[0]),
    .rdata(rdata[0]), .err(err[0]));

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC1)) u_dut_w0 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .byte_en(be[1]),
    .addr(addr[1]), .wdata(wdata[1]), .ready(ready[1]), .ack(ack[1]),
    .rdata(rdata[1]), .err(err[1]));

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h (cycle %0d)", nm, k, act, want, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        we, be, err;
    logic [31:0] addr, wdata, rdata;
    int          due;
  } exp_t;

  exp_t        pend [2];
  bit          pv   [2];
  logic [31:0] mm   [2][DEPTH];

  function automatic logic model_err(input logic b, input logic [31:0] a);
    return ((a >> 2) >= 32'(DEPTH)) || (!b && (a[1:0] != 2'b00));
  endfunction

  // Compare process: outputs against the model every cycle.
  always @(negedge clk) begin
    bit exp_rdy, exp_ack;
    int idx, sh, wc;
    logic [31:0] w;
    for (int k = 0; k < 2; k++) begin
      if (reset !== 1'b1) begin
        chk("rst_ready", k, ready[k], 0);
        chk("rst_ack",   k, ack[k],   0);
        chk("rst_rdata", k, rdata[k], 0);
        chk("rst_err",   k, err[k],   0);
        pv[k] = 0;
      end else begin
        exp_rdy = !pv[k];
        exp_ack = pv[k] && (cyc == pend[k].due);
        chk("ready", k, ready[k], exp_rdy);
        chk("ack",   k, ack[k],   exp_ack);
        if (exp_ack) begin
          chk("rdata", k, rdata[k], pend[k].rdata);
          chk("err",   k, err[k],   pend[k].err);
          if (pend[k].we && !pend[k].err) begin
            idx = int'(pend[k].addr >> 2);
            if (pend[k].be) begin
              sh = 8 * int'(pend[k].addr[1:0]);
              mm[k][idx] = (mm[k][idx] & ~(32'hff << sh)) | ((pend[k].wdata & 32'hff) << sh);
            end else begin
              mm[k][idx] = pend[k].wdata;
            end
          end
          pv[k] = 0;
        end else begin
          chk("idle_rdata", k, rdata[k], 0);
          chk("idle_err",   k, err[k],   0);
        end
        if (exp_rdy && req[k] === 1'b1) begin
          wc = (k == 0) ? WC0 : WC1;
          pend[k].we    = we[k];
          pend[k].be    = be[k];
          pend[k].addr  = addr[k];
          pend[k].wdata = wdata[k];
          pend[k].err   = model_err(be[k], addr[k]);
          pend[k].due   = cyc + wc + 1;
          pend[k].rdata = 32'b0;
          if (!we[k] && !pend[k].err) begin
            w = mm[k][int'(addr[k] >> 2)];
            pend[k].rdata = be[k] ? ((w >> (8 * int'(addr[k][1:0]))) & 32'hff) : w;
          end
          pv[k] = 1;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic xact(input int k, input logic w, input logic b, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output logic er,
                      output int lat);
    int n, t0;
    rd = 'x; er = 'x; lat = -1;
    @(posedge clk); #1;
    req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (ready[k] === 1'b1) break;
      if (++n > 50) begin
        total++; bad++;
        $display("FAIL accept_timeout[%0d] got=no_ready want=ready", k);
        req[k] = 1'b0;
        return;
      end
    end
    t0 = cyc;
    @(posedge clk); #1;
    req[k] = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (ack[k] === 1'b1) break;
      if (++n > 50) begin
        total++; bad++;
        $display("FAIL ack_timeout[%0d] got=no_ack want=ack", k);
        return;
      end
    end
    lat = cyc - t0;
    rd  = rdata[k];
    er  = err[k];
  endtask

  initial begin
    logic [31:0] rd, a, d;
    logic        er, w, b;
    int          lat, r;

    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req[k] = 0; we[k] = 0; be[k] = 0; addr[k] = 0; wdata[k] = 0; pv[k] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_ready_lit", 0, ready[0], 0);
    chk("reset_ready_lit", 1, ready[1], 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_ready_lit", 0, ready[0], 1);

    // Fill both memories so every later load has a known model value.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++)
        xact(k, 1, 0, 32'(i * 4), $urandom, rd, er, lat);

    // Word store then load, 2 wait states.
    xact(0, 1, 0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("t1_st_lat", 0, lat, 3);
    chk("t1_st_rd",  0, rd,  0);
    xact(0, 0, 0, 32'h10, 32'h0, rd, er, lat);
    chk("t1_ld_lat", 0, lat, 3);
    chk("t1_ld_rd",  0, rd,  32'hDEADBEEF);
    chk("t1_ld_err", 0, er,  0);
    // Same on the zero-wait instance.
    xact(1, 1, 0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("t1_st_lat", 1, lat, 1);
    xact(1, 0, 0, 32'h10, 32'h0, rd, er, lat);
    chk("t1_ld_lat", 1, lat, 1);
    chk("t1_ld_rd",  1, rd,  32'hDEADBEEF);

    // Byte store merges into one lane only.
    xact(0, 1, 0, 32'h20, 32'h11223344, rd, er, lat);
    xact(0, 1, 1, 32'h22, 32'h55AACCAB, rd, er, lat);
    xact(0, 0, 0, 32'h20, 32'h0, rd, er, lat);
    chk("t2_word", 0, rd, 32'h11AB3344);
    xact(0, 0, 1, 32'h22, 32'h0, rd, er, lat);
    chk("t2_byte", 0, rd, 32'h000000AB);

    // Misaligned word access.
    xact(0, 0, 0, 32'h21, 32'h0, rd, er, lat);
    chk("t3_ld_err", 0, er, 1);
    chk("t3_ld_rd",  0, rd, 0);
    xact(0, 1, 0, 32'h21, 32'hFFFFFFFF, rd, er, lat);
    chk("t3_st_err", 0, er, 1);
    xact(0, 0, 0, 32'h20, 32'h0, rd, er, lat);
    chk("t3_unchanged", 0, rd, 32'h11AB3344);

    // Out of range: first word past the end must not alias word 0.
    xact(0, 1, 0, 32'h0, 32'hCAFEF00D, rd, er, lat);
    xact(0, 0, 0, 32'(DEPTH * 4), 32'h0, rd, er, lat);
    chk("t4_ld_err", 0, er, 1);
    chk("t4_ld_rd",  0, rd, 0);
    xact(0, 1, 0, 32'(DEPTH * 4), 32'h0BADBEEF, rd, er, lat);
    chk("t4_st_err", 0, er, 1);
    xact(0, 0, 0, 32'h0, 32'h0, rd, er, lat);
    chk("t4_no_wrap", 0, rd, 32'hCAFEF00D);

    // Zero wait states, req held: ready and ack alternate.
    @(posedge clk); #1;
    req[1] = 1; we[1] = 1; be[1] = 0; addr[1] = 32'h80; wdata[1] = 32'hA0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5_ready", 1, ready[1], 32'(i % 2 == 0));
      chk("t5_ack",   1, ack[1],   32'(i % 2 == 1));
      @(posedge clk); #1;
      if (i % 2 == 0) begin
        addr[1]  = addr[1] + 4;
        wdata[1] = wdata[1] + 1;
      end
      if (i == 6) req[1] = 0;
    end
    xact(1, 0, 0, 32'h8C, 32'h0, rd, er, lat);
    chk("t5_last", 1, rd, 32'hA3);

    // Reset during WAIT drops the store.
    xact(0, 1, 0, 32'h40, 32'h12345678, rd, er, lat);
    @(posedge clk); #1;
    req[0] = 1; we[0] = 1; be[0] = 0; addr[0] = 32'h40; wdata[0] = 32'h5;
    @(negedge clk);
    chk("t6_accept", 0, ready[0], 1);
    @(posedge clk); #1;
    req[0] = 0;
    reset  = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_rst_ready", 0, ready[0], 0);
      chk("t6_rst_ack",   0, ack[0],   0);
    end
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("t6_rel_ready", 0, ready[0], 1);
    xact(0, 0, 0, 32'h40, 32'h0, rd, er, lat);
    chk("t6_prior", 0, rd, 32'h12345678);

    // Random traffic; the compare process checks every response.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 120; i++) begin
        r = $urandom_range(0, 9);
        a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
        b = 1'($urandom_range(0, 1));
        w = 1'($urandom_range(0, 1));
        d = $urandom;
        if (r == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
        if (r == 1) a = $urandom | 32'h8000_0000;
        if (!b && r >= 2 && r < 8) a[1:0] = 2'b00;
        xact(k, w, b, a, d, rd, er, lat);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
